// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio bus arbiter.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_HIZ   = 8'h00;

    // Owner index width; a 2-requester arbiter still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uio_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping to 0.
module uio_rr_pick
    import uio_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (IDX_W'(j) >= i_ptr)) begin
                o_any       = 1'b1;
                o_idx       = IDX_W'(j);
                o_onehot[j] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (IDX_W'(j) < i_ptr)) begin
                o_any       = 1'b1;
                o_idx       = IDX_W'(j);
                o_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pins: bounded hold, turnaround cycle after a driving owner,
// registered capture of uio_in for a sampling owner.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   dir,
    input  logic [8*N-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [7:0]     rdata,
    output logic           rvalid,
    input  logic [7:0]     uio_in,
    output logic [7:0]     uio_out,
    output logic [7:0]     uio_oe
);

    localparam int IDX_W = idx_width(N);
    localparam int CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    arb_state_t       r_state;
    logic [N-1:0]     r_gnt;
    logic [IDX_W-1:0] r_owner;
    logic             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_ptr;
    logic [7:0]       r_oe;
    logic [7:0]       r_rdata;
    logic             r_rvalid;

    arb_state_t       w_state_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic             w_dir_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [7:0]       w_oe_nxt;
    logic [7:0]       w_rdata_nxt;
    logic             w_rvalid_nxt;

    logic [N-1:0]     w_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_pick_dir;
    logic             w_owner_req;
    logic             w_other_req;
    logic             w_timeout;
    logic             w_release;
    logic [IDX_W-1:0] w_ptr_inc;
    logic [7:0]       w_wsel;

    uio_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // r_gnt is one-hot during GRANT, so masking with it selects the owner's own bits.
    assign w_pick_dir  = |(dir & w_pick_onehot);
    assign w_owner_req = |(req & r_gnt);
    assign w_other_req = |(req & ~r_gnt);
    assign w_timeout   = (r_cnt == CNT_LAST) && w_other_req;
    assign w_release   = !w_owner_req || w_timeout;
    assign w_ptr_inc   = (r_owner == IDX_LAST) ? '0 : r_owner + IDX_W'(1);

    always_comb begin
        w_wsel = 8'h00;
        for (int j = 0; j < N; j++) begin
            if (r_gnt[j]) begin
                w_wsel = wdata[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_oe     <= OE_HIZ;
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_dir    <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_oe     <= w_oe_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rvalid <= w_rvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_owner_nxt  = r_owner;
        w_dir_nxt    = r_dir;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_oe_nxt     = r_oe;
        w_rdata_nxt  = r_rdata;
        w_rvalid_nxt = 1'b0;

        if (!ena) begin
            // Disable releases the bus straight to IDLE; no turnaround, pointer untouched.
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_oe_nxt    = OE_HIZ;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        w_state_nxt = GRANT;
                        w_gnt_nxt   = w_pick_onehot;
                        w_owner_nxt = w_pick_idx;
                        w_dir_nxt   = w_pick_dir;
                        w_cnt_nxt   = '0;
                        w_oe_nxt    = w_pick_dir ? OE_DRIVE : OE_HIZ;
                    end
                end
                GRANT: begin
                    if (!r_dir) begin
                        w_rdata_nxt  = uio_in;
                        w_rvalid_nxt = 1'b1;
                    end
                    if (w_release) begin
                        w_state_nxt = r_dir ? TURN : IDLE;
                        w_gnt_nxt   = '0;
                        w_oe_nxt    = OE_HIZ;
                        w_cnt_nxt   = '0;
                        w_ptr_nxt   = w_ptr_inc;
                    end else if (r_cnt != CNT_LAST) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                TURN: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_oe_nxt    = OE_HIZ;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign uio_oe  = r_oe;
    assign uio_out = ((r_state == GRANT) && r_dir) ? w_wsel : 8'h00;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter; sampled bytes are checked through a scoreboard queue.
module tb_uio_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [7:0]  wd [4];
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb_q [$];
    logic [7:0]  sb_exp;
    int          own;

    assign wdata = {wd[3], wd[2], wd[1], wd[0]};

    uio_bus_arbiter #(
        .N        (4),
        .HOLD_MAX (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .dir     (dir),
        .wdata   (wdata),
        .gnt     (gnt),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [7:0] v);
        uio_in = v;
        sb_q.push_back(v);
    endtask

    // Bus invariants and rdata scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        check("inv_oe_without_gnt", {31'd0, (gnt == 4'd0) && (uio_oe != 8'd0)}, 32'd0);
        check("inv_onehot_gnt", {31'd0, $onehot0(gnt)}, 32'd1);
        if (rvalid) begin
            check("sb_pending", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                check("sb_rdata", {24'd0, rdata}, {24'd0, sb_exp});
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        req    = 4'b0000;
        dir    = 4'b0000;
        wd[0]  = 8'h00;
        wd[1]  = 8'h00;
        wd[2]  = 8'h00;
        wd[3]  = 8'h00;
        uio_in = 8'h00;
        tick(2);
        check("rst_gnt", {28'd0, gnt}, 32'h0);
        check("rst_oe", {24'd0, uio_oe}, 32'h0);
        check("rst_out", {24'd0, uio_out}, 32'h0);
        check("rst_rdata", {24'd0, rdata}, 32'h0);
        check("rst_rvalid", {31'd0, rvalid}, 32'h0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Driving owner 0 for 3 cycles, then turnaround, then sampling owner 1.
        dir    = 4'b0001;
        wd[0]  = 8'hA5;
        uio_in = 8'h3C;
        req    = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ta_gnt0", {28'd0, gnt}, 32'h1);
            check("ta_oe_drive", {24'd0, uio_oe}, 32'hFF);
            check("ta_out_a5", {24'd0, uio_out}, 32'hA5);
        end
        req = 4'b0010;
        tick();
        check("ta_turn_gnt", {28'd0, gnt}, 32'h0);
        check("ta_turn_oe", {24'd0, uio_oe}, 32'h0);
        check("ta_turn_out", {24'd0, uio_out}, 32'h0);
        tick();
        check("ta_idle_gnt", {28'd0, gnt}, 32'h0);
        check("ta_idle_oe", {24'd0, uio_oe}, 32'h0);
        tick();
        check("ta_gnt1", {28'd0, gnt}, 32'h2);
        check("ta_oe_hiz", {24'd0, uio_oe}, 32'h0);
        check("ta_out_zero", {24'd0, uio_out}, 32'h0);
        sample(8'h3C);
        tick();
        sample(8'h5A);
        tick();
        sample(8'hC3);
        req = 4'b0000;
        tick();
        check("ta_rel_gnt", {28'd0, gnt}, 32'h0);
        tick();
        check("ta_rvalid_off", {31'd0, rvalid}, 32'h0);
        check("ta_rdata_hold", {24'd0, rdata}, 32'hC3);

        // Lone holder on 3: no release however long it holds.
        dir   = 4'b1000;
        wd[3] = 8'h77;
        req   = 4'b1000;
        tick();
        check("lone_gnt", {28'd0, gnt}, 32'h8);
        check("lone_oe", {24'd0, uio_oe}, 32'hFF);
        check("lone_out", {24'd0, uio_out}, 32'h77);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("lone_hold", {28'd0, gnt}, 32'h8);
        end

        // Timeout release of 3 once req0 appears; then owner 0 sampling.
        req = 4'b1001;
        tick();
        check("to_turn_gnt", {28'd0, gnt}, 32'h0);
        check("to_turn_oe", {24'd0, uio_oe}, 32'h0);
        tick();
        check("to_idle_gnt", {28'd0, gnt}, 32'h0);
        tick();
        check("to_gnt0", {28'd0, gnt}, 32'h1);
        check("to_oe_hiz", {24'd0, uio_oe}, 32'h0);

        // Owner 0 drops exactly at the hold limit with req2 pending; dir0 flip is ignored.
        req = 4'b0101;
        dir = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            sample(8'h10 + 8'(k));
            if (k == 7) req = 4'b0100;
            check("drop_gnt0", {28'd0, gnt}, 32'h1);
            check("drop_oe_ignores_dir", {24'd0, uio_oe}, 32'h0);
            tick();
        end
        check("drop_rel_gnt", {28'd0, gnt}, 32'h0);
        check("drop_rel_oe", {24'd0, uio_oe}, 32'h0);
        wd[2] = 8'h5C;
        tick();
        check("drop_gnt2", {28'd0, gnt}, 32'h4);
        check("drop_oe2", {24'd0, uio_oe}, 32'hFF);
        check("drop_out2", {24'd0, uio_out}, 32'h5C);

        // Enable low mid-grant: immediate IDLE, pointer kept at 1 so req 0101 picks 2.
        ena = 1'b0;
        tick();
        check("ena_gnt", {28'd0, gnt}, 32'h0);
        check("ena_oe", {24'd0, uio_oe}, 32'h0);
        check("ena_out", {24'd0, uio_out}, 32'h0);
        check("ena_rvalid", {31'd0, rvalid}, 32'h0);
        ena = 1'b1;
        req = 4'b0101;
        tick();
        check("ena_regrant2", {28'd0, gnt}, 32'h4);
        req = 4'b0001;
        tick();
        check("ena_turn_gnt", {28'd0, gnt}, 32'h0);
        tick();
        check("ena_idle_gnt", {28'd0, gnt}, 32'h0);
        tick();
        check("ena_gnt0", {28'd0, gnt}, 32'h1);
        check("ena_oe0", {24'd0, uio_oe}, 32'hFF);
        check("ena_out0", {24'd0, uio_out}, 32'hA5);

        // Asynchronous reset mid-grant.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_oe", {24'd0, uio_oe}, 32'h0);
        check("arst_gnt", {28'd0, gnt}, 32'h0);
        check("arst_out", {24'd0, uio_out}, 32'h0);
        check("arst_rdata", {24'd0, rdata}, 32'h0);
        tick();
        rst_n = 1'b1;
        req   = 4'b0001;
        tick();
        check("arst_regrant", {28'd0, gnt}, 32'h1);
        check("arst_regrant_oe", {24'd0, uio_oe}, 32'hFF);

        // Full round robin, HOLD_MAX cycles each, gaps depend on owner direction.
        req = 4'b0000;
        tick(2);
        dir   = 4'b0101;
        wd[1] = 8'h22;
        wd[3] = 8'h44;
        req   = 4'b1111;
        tick();
        for (int r = 0; r < 5; r++) begin
            own = (1 + r) % 4;
            for (int k = 0; k < 8; k++) begin
                uio_in = 8'(own * 16 + k);
                if (!dir[own[1:0]]) sb_q.push_back(uio_in);
                check("rr_gnt", {28'd0, gnt}, {28'd0, 4'b0001 << own[1:0]});
                check("rr_oe", {24'd0, uio_oe}, dir[own[1:0]] ? 32'hFF : 32'h0);
                check("rr_out", {24'd0, uio_out}, dir[own[1:0]] ? {24'd0, wd[own[1:0]]} : 32'h0);
                tick();
            end
            check("rr_gap_gnt", {28'd0, gnt}, 32'h0);
            check("rr_gap_oe", {24'd0, uio_oe}, 32'h0);
            tick();
            if (dir[own[1:0]]) begin
                check("rr_turn_gnt", {28'd0, gnt}, 32'h0);
                tick();
            end
        end
        check("rr_final_gnt2", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        tick(3);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
